// File: rtl/gpio_input_router.sv
// gpio_input_router
// Input-direction counterpart of the GPIO output pin mux. Each of the 38 caravel
// pads is synchronised (two flops), optionally debounced, then delivered only to
// the team design selected for that pin. Every other design sees 0 on that pin.
// Sticky rise/fall flags per pin feed the wishbone-side register block.
//
// Optional feature macro: GPIO_IN_DEBOUNCE_EN
//   defined   -> per-pin 8-bit stability counter plus filtered level register
//   undefined -> filtered level is the synchroniser output
module gpio_input_router #(
    parameter int NUM_TEAMS       = 12,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [37:0]                   io_in,
    input  logic [31:0]                   pin_0to7_sel,
    input  logic [31:0]                   pin_8to15_sel,
    input  logic [31:0]                   pin_16to23_sel,
    input  logic [31:0]                   pin_24to31_sel,
    input  logic [23:0]                   pin_32to37_sel,
    input  logic [37:0]                   edge_clr,
    output logic [38*(NUM_TEAMS+1)-1:0]   designs_gpio_in_flat,
    output logic [37:0]                   pin_level,
    output logic [37:0]                   pin_rise,
    output logic [37:0]                   pin_fall
);

    localparam int NUM_PINS    = 38;
    localparam int NUM_DESIGNS = NUM_TEAMS + 1;
    localparam int FLAT_W      = NUM_PINS * NUM_DESIGNS;

    // All per-pin selects packed so pin p lives at [4p+3:4p].
    logic [4*NUM_PINS-1:0] sel_all;
    assign sel_all = {pin_32to37_sel, pin_24to31_sel, pin_16to23_sel,
                      pin_8to15_sel, pin_0to7_sel};

    logic [NUM_PINS-1:0] sync1_q;
    logic [NUM_PINS-1:0] sync2_q;
    logic [NUM_PINS-1:0] filtered;
    logic [NUM_PINS-1:0] prev_q;
    logic [NUM_PINS-1:0] rise_q;
    logic [NUM_PINS-1:0] fall_q;
    logic [NUM_PINS-1:0] rise_evt;
    logic [NUM_PINS-1:0] fall_evt;
    logic [FLAT_W-1:0]   route_d;
    logic [FLAT_W-1:0]   route_q;

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= io_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0]          db_cnt [NUM_PINS];
    logic [NUM_PINS-1:0] filt_q;

    // Filtered level only follows sync after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            filt_q <= '0;
            for (int p = 0; p < NUM_PINS; p++) begin
                db_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PINS; p++) begin
                if (sync2_q[p] == filt_q[p]) begin
                    db_cnt[p] <= '0;
                end else if (db_cnt[p] == DB_LAST) begin
                    filt_q[p] <= sync2_q[p];
                    db_cnt[p] <= '0;
                end else begin
                    db_cnt[p] <= db_cnt[p] + 8'd1;
                end
            end
        end
    end

    assign filtered = filt_q;
`else
    assign filtered = sync2_q;
`endif

    assign pin_level = filtered;

    // Route each pin to the single design named by its select; selects above
    // NUM_TEAMS match no design, so the pin is delivered nowhere.
    always_comb begin
        route_d = '0;
        for (int t = 0; t < NUM_DESIGNS; t++) begin
            for (int p = 0; p < NUM_PINS; p++) begin
                if (int'(sel_all[4*p +: 4]) == t) begin
                    route_d[NUM_PINS*t + p] = filtered[p];
                end
            end
        end
    end

    // Routed output is registered so a select change lands one cycle later.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            route_q <= '0;
        end else begin
            route_q <= route_d;
        end
    end

    assign designs_gpio_in_flat = route_q;

    assign rise_evt = filtered & ~prev_q;
    assign fall_evt = ~filtered & prev_q;

    // Sticky edge flags; a new event outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            prev_q <= filtered;
            rise_q <= rise_evt | (rise_q & ~edge_clr);
            fall_q <= fall_evt | (fall_q & ~edge_clr);
        end
    end

    assign pin_rise = rise_q;
    assign pin_fall = fall_q;

endmodule

// File: tb/tb_gpio_input_router.sv
// Testbench for gpio_input_router. Routed outputs are predicted from a small
// routing model when stimulus is driven, queued, and compared when the
// pipeline delivers them. Inputs change and outputs are sampled on negedge.
module tb_gpio_input_router;

    localparam int NT = 12;
    localparam int W  = 38 * (NT + 1);
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int LAT = 3 + 4;
`else
    localparam int LAT = 3;
`endif
    localparam logic [37:0] ALL1 = 38'h3F_FFFF_FFFF;

    // ---------------- clock / reset / signals ----------------
    logic          clk;
    logic          nrst;
    logic [37:0]   io_in;
    logic [151:0]  sel_vec;
    logic [37:0]   edge_clr;
    logic [W-1:0]  designs_gpio_in_flat;
    logic [37:0]   pin_level;
    logic [37:0]   pin_rise;
    logic [37:0]   pin_fall;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp_v;
    int            checks;
    int            failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gpio_input_router #(.NUM_TEAMS(NT), .DEBOUNCE_CYCLES(4)) dut (
        .clk                  (clk),
        .nrst                 (nrst),
        .io_in                (io_in),
        .pin_0to7_sel         (sel_vec[31:0]),
        .pin_8to15_sel        (sel_vec[63:32]),
        .pin_16to23_sel       (sel_vec[95:64]),
        .pin_24to31_sel       (sel_vec[127:96]),
        .pin_32to37_sel       (sel_vec[151:128]),
        .edge_clr             (edge_clr),
        .designs_gpio_in_flat (designs_gpio_in_flat),
        .pin_level            (pin_level),
        .pin_rise             (pin_rise),
        .pin_fall             (pin_fall)
    );

    // ---------------- model / driver tasks ----------------
    function automatic logic [W-1:0] model_route(input logic [37:0] lvl,
                                                 input logic [151:0] sels);
        logic [W-1:0] r;
        r = '0;
        for (int p = 0; p < 38; p++) begin
            for (int t = 0; t <= NT; t++) begin
                if (int'(sels[4*p +: 4]) == t) r[38*t + p] = lvl[p];
            end
        end
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Let inputs propagate, then wipe all edge flags.
    task automatic settle();
        step(LAT + 1);
        edge_clr = '1;
        step(1);
        edge_clr = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        nrst = 1'b0; io_in = ALL1; sel_vec = '0; edge_clr = '0;
        step(2);
        checks++;
        if (designs_gpio_in_flat !== '0) begin
            failures++; $display("FAIL reset_route: got %h expected 0", designs_gpio_in_flat);
        end
        checks++;
        if (pin_level !== '0 || pin_rise !== '0 || pin_fall !== '0) begin
            failures++; $display("FAIL reset_flags: got lvl=%h rise=%h fall=%h expected 0", pin_level, pin_rise, pin_fall);
        end
        nrst = 1'b1;
        exp_q.push_back(model_route(ALL1, sel_vec));
        step(1);
        checks++;
        if (designs_gpio_in_flat !== '0) begin
            failures++; $display("FAIL first_cycle_route: got %h expected 0", designs_gpio_in_flat);
        end
        step(LAT - 2);
        checks++;
        if (designs_gpio_in_flat !== '0) begin
            failures++; $display("FAIL route_latency: got %h expected 0", designs_gpio_in_flat);
        end
        step(1);
        exp_v = exp_q.pop_front();
        checks++;
        if (designs_gpio_in_flat !== exp_v) begin
            failures++; $display("FAIL reset_release_route: got %h expected %h", designs_gpio_in_flat, exp_v);
        end
        checks++;
        if (pin_level !== ALL1) begin
            failures++; $display("FAIL reset_release_level: got %h expected %h", pin_level, ALL1);
        end
        step(1);
        checks++;
        if (pin_rise !== ALL1 || pin_fall !== '0) begin
            failures++; $display("FAIL reset_release_rise: got rise=%h fall=%h expected rise=%h fall=0", pin_rise, pin_fall, ALL1);
        end
    endtask

    task automatic test_route();
        io_in = '0; sel_vec = '0;
        settle();
        sel_vec[7:4] = 4'd5;
        io_in[1] = 1'b1;
        exp_q.push_back(model_route(io_in, sel_vec));
        step(LAT - 1);
        checks++;
        if (designs_gpio_in_flat[38*5 + 1] !== 1'b0) begin
            failures++; $display("FAIL route_early: got %b expected 0", designs_gpio_in_flat[38*5 + 1]);
        end
        step(1);
        exp_v = exp_q.pop_front();
        checks++;
        if (designs_gpio_in_flat !== exp_v) begin
            failures++; $display("FAIL route_pin1_d5: got %h expected %h", designs_gpio_in_flat, exp_v);
        end
        checks++;
        if (designs_gpio_in_flat[38*5 + 1] !== 1'b1 || designs_gpio_in_flat[1] !== 1'b0) begin
            failures++; $display("FAIL route_pin1_bits: got d5=%b d0=%b expected d5=1 d0=0",
                                 designs_gpio_in_flat[38*5 + 1], designs_gpio_in_flat[1]);
        end
    endtask

    task automatic test_sel_change();
        sel_vec[7:4] = 4'd7;
        exp_q.push_back(model_route(io_in, sel_vec));
        step(1);
        exp_v = exp_q.pop_front();
        checks++;
        if (designs_gpio_in_flat !== exp_v) begin
            failures++; $display("FAIL sel_change: got %h expected %h", designs_gpio_in_flat, exp_v);
        end
    endtask

    task automatic test_out_of_range();
        sel_vec[151:148] = 4'hF;
        io_in[37] = 1'b1;
        exp_q.push_back(model_route(io_in, sel_vec));
        step(LAT);
        exp_v = exp_q.pop_front();
        checks++;
        if (designs_gpio_in_flat !== exp_v) begin
            failures++; $display("FAIL out_of_range_route: got %h expected %h", designs_gpio_in_flat, exp_v);
        end
        checks++;
        if (pin_level[37] !== 1'b1 || pin_rise[37] !== 1'b1) begin
            failures++; $display("FAIL out_of_range_flags: got lvl=%b rise=%b expected 1 1", pin_level[37], pin_rise[37]);
        end
    endtask

    task automatic test_edge_flags();
        io_in = '0; sel_vec = '0;
        settle();
        io_in[4] = 1'b1;
        step(LAT);
        checks++;
        if (pin_rise[4] !== 1'b1 || pin_fall[4] !== 1'b0) begin
            failures++; $display("FAIL edge_rise: got rise=%b fall=%b expected 1 0", pin_rise[4], pin_fall[4]);
        end
        io_in[4] = 1'b0;
        step(LAT);
        step(2);
        checks++;
        if (pin_fall[4] !== 1'b1 || pin_rise[4] !== 1'b1) begin
            failures++; $display("FAIL fall_held: got rise=%b fall=%b expected 1 1", pin_rise[4], pin_fall[4]);
        end
        io_in[4] = 1'b1;
        step(LAT - 1);
        edge_clr[4] = 1'b1;
        step(1);
        edge_clr = '0;
        checks++;
        if (pin_rise[4] !== 1'b1) begin
            failures++; $display("FAIL set_wins: got %b expected 1", pin_rise[4]);
        end
        checks++;
        if (pin_fall[4] !== 1'b0) begin
            failures++; $display("FAIL fall_cleared: got %b expected 0", pin_fall[4]);
        end
        step(1);
        edge_clr[4] = 1'b1;
        step(1);
        edge_clr = '0;
        checks++;
        if (pin_rise[4] !== 1'b0) begin
            failures++; $display("FAIL rise_cleared: got %b expected 0", pin_rise[4]);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        for (int i = 0; i < 16; i++) begin
            r = {$urandom, $urandom};
            io_in = r[37:0];
            for (int p = 0; p < 38; p++) sel_vec[4*p +: 4] = 4'($urandom_range(0, 15));
            exp_q.push_back(model_route(io_in, sel_vec));
            step(LAT);
            exp_v = exp_q.pop_front();
            checks++;
            if (designs_gpio_in_flat !== exp_v) begin
                failures++; $display("FAIL rand_route[%0d]: got %h expected %h", i, designs_gpio_in_flat, exp_v);
            end
            checks++;
            if (pin_level !== io_in) begin
                failures++; $display("FAIL rand_level[%0d]: got %h expected %h", i, pin_level, io_in);
            end
        end
        for (int i = 0; i < 12; i++) begin
            for (int p = 0; p < 38; p++) sel_vec[4*p +: 4] = 4'($urandom_range(0, 15));
            exp_q.push_back(model_route(io_in, sel_vec));
            step(1);
            exp_v = exp_q.pop_front();
            checks++;
            if (designs_gpio_in_flat !== exp_v) begin
                failures++; $display("FAIL b2b_sel[%0d]: got %h expected %h", i, designs_gpio_in_flat, exp_v);
            end
        end
    endtask

`ifdef GPIO_IN_DEBOUNCE_EN
    task automatic test_debounce();
        io_in = '0; sel_vec = '0;
        settle();
        io_in[10] = 1'b1;
        step(3);
        io_in[10] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if (pin_level[10] !== 1'b0) begin
                failures++; $display("FAIL db_glitch[%0d]: got %b expected 0", i, pin_level[10]);
            end
        end
        io_in[10] = 1'b1;
        step(5);
        checks++;
        if (pin_level[10] !== 1'b0) begin
            failures++; $display("FAIL db_early: got %b expected 0", pin_level[10]);
        end
        step(1);
        checks++;
        if (pin_level[10] !== 1'b1) begin
            failures++; $display("FAIL db_edge: got %b expected 1", pin_level[10]);
        end
    endtask
`endif

    // ---------------- sequence / report ----------------
    initial begin
        checks = 0; failures = 0;
        nrst = 1'b0; io_in = '0; sel_vec = '0; edge_clr = '0;
        step(1);
        test_reset();
        test_route();
        test_sel_change();
        test_out_of_range();
        test_edge_flags();
        test_back_to_back();
`ifdef GPIO_IN_DEBOUNCE_EN
        test_debounce();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_input_router.md
Name: gpio_input_router

Overview:
- Input-direction counterpart to the GPIO output pin mux.
- Samples the 38 caravel io_in pads and synchronises them, optionally debounced.
- Delivers each pin only to the team design currently selected for that pin; every other team sees 0 on that pin.
- Keeps sticky per-pin rise/fall edge flags for the wishbone-side register block.

Parameters:
- NUM_TEAMS, 12, number of team designs; designs are indexed 0..NUM_TEAMS (index 0 = default/management design).
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before the filtered level changes (only used with GPIO_IN_DEBOUNCE_EN; legal range 1..255).

Ports:
- clk  input  1  system clock.
- nrst  input  1  asynchronous active-low reset.
- io_in  input  38  raw pad inputs, asynchronous to clk.
- pin_0to7_sel  input  32  4-bit design select per pin 0..7 (pin n at bits [4n+3:4n]).
- pin_8to15_sel  input  32  same encoding, pins 8..15.
- pin_16to23_sel  input  32  same encoding, pins 16..23.
- pin_24to31_sel  input  32  same encoding, pins 24..31.
- pin_32to37_sel  input  24  same encoding, pins 32..37.
- edge_clr  input  38  write-1-to-clear pulse per pin for edge flags.
- designs_gpio_in_flat  output  38*(NUM_TEAMS+1)  routed inputs; design t occupies bits [38t+37:38t].
- pin_level  output  38  filtered pin level.
- pin_rise  output  38  sticky rising-edge flags.
- pin_fall  output  38  sticky falling-edge flags.

Behaviour:
- Reset (nrst low, async):
  - sync stages, filtered level, previous level, debounce counters, routed output register and edge flags all clear to 0.
  - Outputs are 0 during reset and on the first cycle after release.
- Synchroniser: two flops per pin, sync = stage2.
- Filtered level: equals sync (combinational) without the optional feature; see Optional Feature for the debounced case.
- pin_level = filtered, unregistered beyond the filter.
- Routing register, updated every cycle: design t, bit p <= filtered[p] when sel[p] == t, else 0.
  - A sel value > NUM_TEAMS (e.g. 13..15 with default NUM_TEAMS) routes the pin to no design.
  - A sel change takes effect on the routed output one cycle later.
  - Exactly one design may see a given pin at a time.
- Latency, pad edge to designs_gpio_in_flat: 3 clk without debounce (2 sync + 1 route).
- Edge detection:
  - prev <= filtered each cycle.
  - rise_evt = filtered & ~prev; fall_evt = ~filtered & prev.
  - pin_rise[p] set by rise_evt[p] and held until edge_clr[p]=1; pin_fall likewise.
  - Simultaneous set and clear on the same pin: set wins (flag stays 1).
  - Flags update one cycle after the event.
- Edge flags are independent of the pin select; unselected pins still flag.
- Pulses shorter than one clk may be missed; no requirement to catch them.
- Mid-operation reset: all state clears immediately; first sampled value after release propagates normally, and a pin already high at release produces a rise flag.

Optional Feature:
- Macro: GPIO_IN_DEBOUNCE_EN.
- Defined: each pin has an 8-bit counter and a filtered register.
  - sync == filtered: counter <= 0.
  - sync != filtered and counter == DEBOUNCE_CYCLES-1: filtered <= sync, counter <= 0.
  - Otherwise: counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES clk never changes filtered.
  - Pad-to-route latency becomes 3 + DEBOUNCE_CYCLES clk.
- Undefined: no counters; filtered = sync; latency 3 clk.

Test Plan:
- Reset release, io_in=38'h3F_FFFF_FFFF, all sel=0 (no debounce) → design 0 slice = all 1s from cycle 3; designs 1..12 = 0; pin_rise = all 1s at cycle 4.
- pin_0to7_sel=32'h0000_0050 (pin1→5), io_in[1] 0→1 → design 5 bit 1 rises after 3 clk; design 0 bit 1 stays 0; other designs 0.
- Select change: pin 1 sel 5→7 with io_in[1]=1 → next cycle design 5 bit1=0 and design 7 bit1=1.
- Out-of-range select: pin 37 sel=4'hF, io_in[37]=1 → no design sees bit 37; pin_level[37]=1 and pin_rise[37]=1.
- Edge flags: io_in[4] 0→1→0, then edge_clr[4]=1 on the same cycle as a new rise → pin_rise[4] stays 1; a later clear with no event → 0; pin_fall[4]=1 until cleared.
- With GPIO_IN_DEBOUNCE_EN, DEBOUNCE_CYCLES=4:
  - 3-cycle-wide high glitch on io_in[10] → pin_level[10] stays 0.
  - Steady high → pin_level[10]=1 exactly 2+4 clk after the pad edge.
